// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: instruction ROM read port, redirect request and the
// instruction valid/ready handshake toward the decoder.
interface ifetch_queue_if #(
  parameter int SCALE = 10
);
  logic             rom_oe;
  logic [SCALE-1:0] rom_addr;
  logic [31:0]      rom_rdata;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;

  modport master (
    output rom_oe, rom_addr, inst_valid, inst, inst_pc,
    input  rom_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  rom_oe, rom_addr, inst_valid, inst, inst_pc,
    output rom_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues ROM reads under a credit limit, buffers the
// returning words with their PCs, and flushes everything on a redirect.
module ifetch_queue #(
  parameter int          SCALE    = 10,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic         clk,
  input logic         rst,
  ifetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_CREDIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_COUNT  = CW'(DEPTH);

  logic [31:0]   pc;
  logic          running;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          issue;
  logic          wr;
  logic          pop;
  logic          qvalid;
  logic [CW:0]   credit;

  // Credit counts the in-flight read so a returning word always has a slot;
  // a pop in the same cycle frees its slot only from the next cycle on.
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue  = running && !bus.redirect && (credit < DEPTH_CREDIT);

  assign bus.rom_oe   = issue;
  assign bus.rom_addr = pc[SCALE+1:2];

  assign qvalid         = (count != '0);
  assign bus.inst_valid = qvalid && !bus.redirect;
  assign bus.inst       = qvalid ? q_inst[rd_ptr] : '0;
  assign bus.inst_pc    = qvalid ? q_pc[rd_ptr]   : '0;

  assign pop = bus.inst_valid && bus.inst_ready;
  assign wr  = inflight && !bus.redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      running     <= 1'b0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      running <= 1'b1;
      if (bus.redirect) begin
        pc       <= bus.redirect_pc & ~32'h3;
        inflight <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= pc;
          pc          <= pc + 32'd4;
        end
        if (wr)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        case ({wr, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (wr) begin
      q_inst[wr_ptr] <= bus.rom_rdata;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst)
    wr |-> (count < DEPTH_COUNT));

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus a long random
// run against a queue-of-issued-PCs reference model.
module tb_ifetch_queue;

  localparam int          SCALE    = 10;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if #(.SCALE(SCALE)) bus();

  ifetch_queue #(.SCALE(SCALE), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom_word(input logic [SCALE-1:0] a);
    return 32'(a) + 32'd100;
  endfunction

  // ROM with one-cycle read latency; garbage whenever not enabled
  always @(posedge clk)
    bus.rom_rdata <= bus.rom_oe ? rom_word(bus.rom_addr) : $urandom;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_run;
  int          cyc;
  logic [31:0] seen[$];
  int          n_oe;

  task automatic model_reset(input bit run_next);
    mq.delete();
    m_pc  = RESET_PC;
    m_run = run_next;
  endtask

  task automatic check_and_step();
    bit e_oe, e_val;
    e_oe  = m_run && !bus.redirect && (mq.size() < DEPTH);
    e_val = !bus.redirect && (mq.size() > 0) && ((cyc - mq[0].cyc) >= 2);
    chk("rom_oe", 32'(bus.rom_oe), 32'(e_oe));
    chk("rom_addr", 32'(bus.rom_addr), 32'(m_pc[SCALE+1:2]));
    chk("inst_valid", 32'(bus.inst_valid), 32'(e_val));
    if (e_val) begin
      chk("inst_pc", bus.inst_pc, mq[0].pc);
      chk("inst", bus.inst, rom_word(mq[0].pc[SCALE+1:2]));
    end
    if (bus.inst_valid && bus.inst_ready) seen.push_back(bus.inst_pc);
    if (bus.rom_oe) n_oe++;
    if (bus.redirect) begin
      mq.delete();
      m_pc = bus.redirect_pc & ~32'h3;
    end else begin
      if (e_val && bus.inst_ready) void'(mq.pop_front());
      if (e_oe) begin
        mq.push_back('{pc: m_pc, cyc: cyc});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = 1'b1;
    cyc++;
  endtask

  task automatic cycle(input bit r, input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.inst_ready  = rdy;
    #1;
    check_and_step();
  endtask

  task automatic chk_seen(input string tag, input int idx, input logic [31:0] exp);
    if (idx < seen.size()) chk(tag, seen[idx], exp);
    else chk(tag, 32'(seen.size()), 32'(idx + 1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oe"},    32'(bus.rom_oe), 32'd0);
    chk({tag, "_addr"},  32'(bus.rom_addr), 32'(RESET_PC[SCALE+1:2]));
    chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_inst"},  bus.inst, 32'd0);
    chk({tag, "_pc"},    bus.inst_pc, 32'd0);
  endtask

  initial begin
    int d0, o0;
    bit r, rdy;
    logic [31:0] rpc;

    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;
    cyc  = 0;
    n_oe = 0;
    model_reset(1'b0);

    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("rst");

    // release between edges; account for the cycle before the first edge
    rst = 1'b1;
    bus.inst_ready = 1'b1;
    #1;
    check_and_step();

    // streaming from reset
    repeat (8) cycle(1'b0, '0, 1'b1);
    chk_seen("stream0", 0, 32'd0);
    chk_seen("stream1", 1, 32'd4);
    chk_seen("stream2", 2, 32'd8);

    // consumer stalled: exactly DEPTH issues, head held
    cycle(1'b1, 32'h0, 1'b0);
    o0 = n_oe;
    repeat (8) cycle(1'b0, '0, 1'b0);
    chk("stall_issues", 32'(n_oe - o0), 32'(DEPTH));
    chk("stall_oe", 32'(bus.rom_oe), 32'd0);
    chk("stall_valid", 32'(bus.inst_valid), 32'd1);
    chk("stall_head", bus.inst_pc, 32'd0);
    d0 = seen.size();
    repeat (10) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) chk_seen("drain", d0 + i, 32'(4 * i));

    // redirect while queue and in-flight slot are all occupied
    cycle(1'b1, 32'h200, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b0);
    d0 = seen.size();
    cycle(1'b1, 32'h43, 1'b1);
    chk("redir_valid", 32'(bus.inst_valid), 32'd0);
    chk("redir_oe", 32'(bus.rom_oe), 32'd0);
    cycle(1'b0, '0, 1'b1);
    chk("redir_next_oe", 32'(bus.rom_oe), 32'd1);
    chk("redir_next_addr", 32'(bus.rom_addr), 32'h10);
    repeat (6) cycle(1'b0, '0, 1'b1);
    chk_seen("redir_first", d0, 32'h40);
    chk_seen("redir_second", d0 + 1, 32'h44);

    // PC wrap at the top of the address space
    d0 = seen.size();
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("wrap_addr_hi", 32'(bus.rom_addr), 32'h3FF);
    cycle(1'b0, '0, 1'b1);
    chk("wrap_addr_lo", 32'(bus.rom_addr), 32'h0);
    repeat (5) cycle(1'b0, '0, 1'b1);
    chk_seen("wrap_pc_hi", d0, 32'hFFFF_FFFC);
    chk_seen("wrap_pc_lo", d0 + 1, 32'h0);

    // short asynchronous reset pulse mid-stream
    cycle(1'b1, 32'h800, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b1);
    bus.redirect = 1'b0;
    #1 rst = 1'b0;
    #1 chk_reset_outputs("arst");
    #1 rst = 1'b1;
    model_reset(1'b1);
    d0 = seen.size();
    cycle(1'b0, '0, 1'b1);
    chk("arst_restart_oe", 32'(bus.rom_oe), 32'd1);
    chk("arst_restart_addr", 32'(bus.rom_addr), 32'(RESET_PC[SCALE+1:2]));
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk_seen("arst_first", d0, RESET_PC);

    // random consumer backpressure and redirects
    for (int i = 0; i < 10000; i++) begin
      r   = ($urandom_range(0, 99) < 3);
      rdy = ($urandom_range(0, 99) < 70);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      cycle(r, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
